pll_reconfig_ctrl: RTL and testbench
====================================

Name: pll_reconfig_ctrl

Overview:
- Sequences run-time frequency changes of the hashing-core PLL (altpll, Cyclone III) by rewriting its M and C0 counter settings over the PLL scan chain, then resetting the PLL and waiting for relock.
- Sits between the host/JTAG command path and the main PLL instance.
- Holds the hashing cores (`hold`) whenever the PLL output is not trustworthy.

Parameters:
- CHAIN_LEN, 144: scan chain length in bits, shifted MSB first.
- DEFAULT_CHAIN, 144'h0: power-on shadow image of the full chain.
- M_OFS, 0: bit index of the LSB of the 18-bit M-counter field in the shadow.
- C0_OFS, 36: bit index of the LSB of the 18-bit C0-counter field.
- MAXV, 255: largest legal mult/div value.
- ARESET_CYC, 16: cycles that areset is held high.
- LOCK_STABLE, 1024: cycles `locked` must stay continuously high before success.
- TIMEOUT, 1048576: cycle budget for WAIT_DONE and for WAIT_LOCK, each counted separately.

Ports:
- clk  in  1  system clock; also the source of scanclk.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  in  1  single-cycle request; sampled only in IDLE.
- mult  in  8  new M value, legal range 1..MAXV.
- div  in  8  new C0 value, legal range 1..MAXV.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on success.
- error  out  1  one-cycle pulse on failure.
- err_code  out  2  0 = none, 1 = bad value, 2 = scandone timeout, 3 = lock timeout; held until the next req.
- hold  out  1  stalls the hashers.
- scanclk, scandata, scanclkena, configupdate, areset  out  1 each  PLL reconfig pins.
- scandone, locked  in  1 each  PLL status.

Behaviour:
- Reset values: all outputs 0 except hold = 1; shadow register = DEFAULT_CHAIN; state = IDLE.
- Counter field encoding for a value v, as an 18-bit word {bypass, high[7:0], odd, low[7:0]}:
  - v == 1: bypass = 1, all other bits 0.
  - otherwise: high = ceil(v/2), low = floor(v/2), odd = v[0], bypass = 0.
- IDLE:
  - hold = ~locked, registered, so one cycle of lag.
  - req with mult or div equal to 0 or greater than MAXV: error pulses the next cycle, err_code = 1, state stays IDLE.
  - req with legal values: go to LOAD. err_code clears to 0 on any req.
- LOAD (1 cycle): write the M and C0 fields into the shadow; reset the bit counter to CHAIN_LEN-1; go to SHIFT.
- SHIFT (2 cycles per bit):
  - Phase A: scanclk = 0, scandata = shadow[bit].
  - Phase B: scanclk = 1.
  - scanclkena = 1 throughout SHIFT.
  - After the phase B of bit 0, go to UPDATE.
  - Total duration is exactly 2*CHAIN_LEN cycles.
- UPDATE (1 cycle): scanclk = 0, scanclkena = 0, configupdate = 1. Go to WAIT_DONE.
- WAIT_DONE:
  - scandone high: go to PLLRST.
  - TIMEOUT cycles elapse first: go to FAIL with code 2.
- PLLRST: areset = 1 for exactly ARESET_CYC cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - A stable counter increments while locked = 1 and clears to 0 when locked drops.
  - Counter reaches LOCK_STABLE: go to DONE.
  - TIMEOUT counter expires first: go to FAIL with code 3.
- DONE (1 cycle): done = 1; go to IDLE.
- FAIL (1 cycle): error = 1, err_code latched; areset = 0; go to IDLE.
- hold = 1 in every state other than IDLE.
- A req arriving in any non-IDLE state is ignored; there is no queue.
- reset_n low in any state aborts the operation within the same edge, and all outputs return to their reset values, so areset, scanclkena and configupdate drop immediately.
- The shadow keeps the last successfully loaded fields across operations. After a FAIL the shadow still contains the attempted values.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `pll_reconfig_pkg`:
  - state enum.
  - err_code constants.
  - 18-bit field type.
  - function `cnt_field(v)` implementing the encoding above.
- Sub-module `scan_shifter`: a CHAIN_LEN-bit parallel-load, MSB-first shifter with the two-phase scanclk generator and a last_bit flag. The controller FSM instantiates it.

Test Plan:
- Encoding: req with mult = 5, div = 6 → captured chain has M field 18'h00702 and C0 field 18'h00603; scanclk rises 144 times; configupdate pulses exactly once, 1 cycle after the final scanclk rise.
- Bypass and success: mult = 1, div = 1 → both fields 18'h20000. Then drive scandone 10 cycles after configupdate and hold locked = 1 → areset high 16 cycles; done pulses 1024 cycles after locked rises; hold = 1 throughout and drops 1 cycle after IDLE is re-entered.
- Bad value: mult = 0 → error pulse, err_code = 1, busy never asserts, no scanclk edges.
- Lock loss and timeout: locked toggles low every 500 cycles in WAIT_LOCK → stable counter never reaches 1024; at the TIMEOUT expiry error pulses with err_code = 3 and areset = 0.
- Scandone timeout and ignored req: scandone never asserted → err_code = 2. A req issued mid-SHIFT is ignored and the chain contents are unchanged.
- Reset mid-operation: reset_n low in cycle 100 of SHIFT → next cycle scanclkena = 0, busy = 0, hold = 1, shadow = DEFAULT_CHAIN.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the PLL scan-chain reconfiguration controller.
// Holds the FSM state encoding, error codes and the counter-field encoder.
package pll_reconfig_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_UPDATE,
      ST_WAIT_DONE,
      ST_PLLRST,
      ST_WAIT_LOCK,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_BAD_VALUE = 2'd1;
   localparam logic [1:0] ERR_SCANDONE  = 2'd2;
   localparam logic [1:0] ERR_LOCK      = 2'd3;

   localparam int FIELD_W = 18;

   typedef logic [FIELD_W-1:0] cnt_field_t;

   // Layout {bypass, high[7:0], odd, low[7:0]}; an odd count puts the extra cycle in high.
   function automatic cnt_field_t cnt_field(input logic [7:0] v);
      cnt_field_t f;
      logic [7:0] half;
      f    = '0;
      half = {1'b0, v[7:1]};
      if (v == 8'd1) begin
         f[17] = 1'b1;
      end else begin
         f[16:9] = half + {7'd0, v[0]};
         f[8]    = v[0];
         f[7:0]  = half;
      end
      return f;
   endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_scan_shifter.sv
// MSB-first parallel-load shifter that drives the PLL scan chain.
// Each bit takes two cycles: scanclk low with data valid, then scanclk high.
module scan_shifter
   import pll_reconfig_pkg::*;
#(
   parameter int CHAIN_LEN = 144
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic                 shift_en,
   input  logic [CHAIN_LEN-1:0] image,
   output logic                 scanclk,
   output logic                 scandata,
   output logic                 last_bit
);

   localparam int CW = $clog2(CHAIN_LEN);

   logic [CHAIN_LEN-1:0] sr;
   logic [CW-1:0]        bit_cnt;

   // The register is advanced on the rising scanclk edge so that scandata can be
   // refreshed from its MSB on the following falling edge and stay stable while high.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sr       <= '0;
         bit_cnt  <= '0;
         scanclk  <= 1'b0;
         scandata <= 1'b0;
      end else if (load) begin
         sr       <= image;
         bit_cnt  <= CW'(CHAIN_LEN - 1);
         scanclk  <= 1'b0;
         scandata <= image[CHAIN_LEN-1];
      end else if (shift_en) begin
         if (!scanclk) begin
            scanclk <= 1'b1;
            sr      <= {sr[CHAIN_LEN-2:0], 1'b0};
         end else begin
            scanclk <= 1'b0;
            if (last_bit) begin
               scandata <= 1'b0;
            end else begin
               scandata <= sr[CHAIN_LEN-1];
               bit_cnt  <= bit_cnt - 1'b1;
            end
         end
      end
   end

   assign last_bit = scanclk && (bit_cnt == '0);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Rewrites the hashing-core PLL M/C0 counters over the scan chain, resets the
// PLL and waits for a stable relock, holding the hashers while the clock is suspect.
module pll_reconfig_ctrl
   import pll_reconfig_pkg::*;
#(
   parameter int                   CHAIN_LEN     = 144,
   parameter logic [CHAIN_LEN-1:0] DEFAULT_CHAIN = '0,
   parameter int                   M_OFS         = 0,
   parameter int                   C0_OFS        = 36,
   parameter int                   MAXV          = 255,
   parameter int                   ARESET_CYC    = 16,
   parameter int                   LOCK_STABLE   = 1024,
   parameter int                   TIMEOUT       = 1048576
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic [7:0] mult,
   input  logic [7:0] div,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code,
   output logic       hold,
   output logic       scanclk,
   output logic       scandata,
   output logic       scanclkena,
   output logic       configupdate,
   output logic       areset,
   input  logic       scandone,
   input  logic       locked
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int SW = $clog2(LOCK_STABLE) + 1;
   localparam int AW = $clog2(ARESET_CYC) + 1;

   state_t               state;
   logic [CHAIN_LEN-1:0] shadow;
   logic [CHAIN_LEN-1:0] next_shadow;
   logic [7:0]           mult_q;
   logic [7:0]           div_q;
   logic [TW-1:0]        tmo_cnt;
   logic [SW-1:0]        stable_cnt;
   logic [AW-1:0]        ares_cnt;
   logic                 req_legal;
   logic                 shift_load;
   logic                 shift_en;
   logic                 last_bit;

   assign req_legal = (mult != 8'd0) && (div != 8'd0) &&
                      (int'(mult) <= MAXV) && (int'(div) <= MAXV);

   always_comb begin
      next_shadow                    = shadow;
      next_shadow[M_OFS  +: FIELD_W] = cnt_field(mult_q);
      next_shadow[C0_OFS +: FIELD_W] = cnt_field(div_q);
   end

   assign shift_load = (state == ST_LOAD);
   assign shift_en   = (state == ST_SHIFT);

   scan_shifter #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_shifter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (shift_load),
      .shift_en (shift_en),
      .image    (next_shadow),
      .scanclk  (scanclk),
      .scandata (scandata),
      .last_bit (last_bit)
   );

   // Outputs are assigned on the edge entering each state, so they line up with it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         shadow       <= DEFAULT_CHAIN;
         mult_q       <= '0;
         div_q        <= '0;
         tmo_cnt      <= '0;
         stable_cnt   <= '0;
         ares_cnt     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= ERR_NONE;
         hold         <= 1'b1;
         scanclkena   <= 1'b0;
         configupdate <= 1'b0;
         areset       <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               hold <= ~locked;
               if (req) begin
                  err_code <= ERR_NONE;
                  if (req_legal) begin
                     mult_q <= mult;
                     div_q  <= div;
                     busy   <= 1'b1;
                     hold   <= 1'b1;
                     state  <= ST_LOAD;
                  end else begin
                     error    <= 1'b1;
                     err_code <= ERR_BAD_VALUE;
                  end
               end
            end
            ST_LOAD: begin
               shadow     <= next_shadow;
               scanclkena <= 1'b1;
               state      <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (last_bit) begin
                  scanclkena   <= 1'b0;
                  configupdate <= 1'b1;
                  state        <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               configupdate <= 1'b0;
               tmo_cnt      <= '0;
               state        <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (scandone) begin
                  areset   <= 1'b1;
                  ares_cnt <= '0;
                  state    <= ST_PLLRST;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  error    <= 1'b1;
                  err_code <= ERR_SCANDONE;
                  state    <= ST_FAIL;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_PLLRST: begin
               if (ares_cnt == AW'(ARESET_CYC - 1)) begin
                  areset     <= 1'b0;
                  stable_cnt <= '0;
                  tmo_cnt    <= '0;
                  state      <= ST_WAIT_LOCK;
               end else begin
                  ares_cnt <= ares_cnt + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (locked && (stable_cnt == SW'(LOCK_STABLE - 1))) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  error    <= 1'b1;
                  err_code <= ERR_LOCK;
                  areset   <= 1'b0;
                  state    <= ST_FAIL;
               end else begin
                  tmo_cnt    <= tmo_cnt + 1'b1;
                  stable_cnt <= locked ? stable_cnt + 1'b1 : '0;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_FAIL: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: table-driven operations with a small
// PLL model, expected outcomes queued per request, plus a mid-shift reset sequence.
module tb_pll_reconfig_ctrl;

   localparam int           CHAIN_LEN = 144;
   localparam logic [143:0] DEF_CHAIN = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_5A5A;
   localparam int           TMO       = 3000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req = 1'b0;
   logic [7:0] mult = '0;
   logic [7:0] div = '0;
   logic       scandone = 1'b0;
   logic       locked = 1'b1;
   logic       busy, done, error, hold;
   logic [1:0] err_code;
   logic       scanclk, scandata, scanclkena, configupdate, areset;

   always #5 clk = ~clk;

   pll_reconfig_ctrl #(
      .CHAIN_LEN     (CHAIN_LEN),
      .DEFAULT_CHAIN (DEF_CHAIN),
      .M_OFS         (0),
      .C0_OFS        (36),
      .MAXV          (255),
      .ARESET_CYC    (16),
      .LOCK_STABLE   (1024),
      .TIMEOUT       (TMO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req          (req),
      .mult         (mult),
      .div          (div),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .err_code     (err_code),
      .hold         (hold),
      .scanclk      (scanclk),
      .scandata     (scandata),
      .scanclkena   (scanclkena),
      .configupdate (configupdate),
      .areset       (areset),
      .scandone     (scandone),
      .locked       (locked)
   );

   typedef struct {
      logic [7:0]  mult;
      logic [7:0]  div;
      int          sd_dly;
      bit          toggle;
      bit          mid_req;
      logic [1:0]  exp_err;
      logic [17:0] exp_m;
      logic [17:0] exp_c0;
   } vec_t;

   typedef struct {
      logic [143:0] chain;
      logic [1:0]   err;
      bit           ok;
      bit           legal;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[6];
   vec_t post_rst;
   int   tests;
   int   fails;

   logic [143:0] obs_chain;
   int           obs_rises, obs_cfg, obs_cfg_gap, obs_areset_len, obs_busy, obs_hold_viol;
   int           obs_done, obs_err, obs_lock2done;
   logic         obs_areset_at_err, obs_busy_t1, obs_hold_t1, obs_hold_t2, obs_finished;
   logic [1:0]   obs_code, obs_code_held;

   function automatic logic [17:0] modelField(input int v);
      if (v == 1) return 18'h20000;
      return 18'(((v + 1) / 2) * 512 + (v % 2) * 256 + v / 2);
   endfunction

   task automatic compare(input string name, input logic [143:0] act, input logic [143:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // Issues one request and runs the PLL model until the outcome pulse plus three idle cycles.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      int   n, last_rise, sd_at, fall_idx, lock_idx, trail, t;
      logic prev_sclk, prev_ares, nl;
      e.legal = (v.mult != 8'd0) && (v.div != 8'd0);
      e.chain = DEF_CHAIN;
      e.chain[17:0]  = v.exp_m;
      e.chain[53:36] = v.exp_c0;
      e.err   = v.exp_err;
      e.ok    = (v.exp_err == 2'd0);
      exp_q.push_back(e);

      obs_chain = '0; obs_rises = 0; obs_cfg = 0; obs_cfg_gap = -1; obs_areset_len = 0;
      obs_busy = 0; obs_hold_viol = 0; obs_done = 0; obs_err = 0; obs_lock2done = -1;
      obs_areset_at_err = 1'bx; obs_busy_t1 = 1'bx; obs_hold_t1 = 1'bx; obs_hold_t2 = 1'bx;
      obs_finished = 1'b0; obs_code = 2'bxx; obs_code_held = 2'bxx;

      locked = 1'b1;
      scandone = 1'b0;
      mult = v.mult;
      div = v.div;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;

      n = 0; last_rise = -1; sd_at = -1; fall_idx = -1; lock_idx = -1; trail = 0;
      prev_sclk = 1'b0; prev_ares = 1'b0;
      while (n < 8000 && trail < 3) begin
         if (scanclk && !prev_sclk) begin
            obs_rises++;
            obs_chain = {obs_chain[142:0], scandata};
            last_rise = n;
         end
         if (configupdate) begin
            obs_cfg++;
            obs_cfg_gap = n - last_rise;
            if (v.sd_dly >= 0) sd_at = n + v.sd_dly;
         end
         if (areset) obs_areset_len++;
         if (!areset && prev_ares) fall_idx = n;
         if (busy) obs_busy++;
         if (busy && !hold) obs_hold_viol++;
         if (done) begin
            obs_done++;
            obs_lock2done = n - lock_idx;
         end
         if (error) begin
            obs_err++;
            obs_code = err_code;
            obs_areset_at_err = areset;
         end
         if (obs_finished) begin
            trail++;
            if (trail == 1) begin
               obs_busy_t1 = busy;
               obs_hold_t1 = hold;
            end
            if (trail == 2) obs_hold_t2 = hold;
            obs_code_held = err_code;
         end else if (done || error) begin
            obs_finished = 1'b1;
         end
         prev_sclk = scanclk;
         prev_ares = areset;

         req = 1'b0;
         if (v.mid_req && obs_rises == 50 && n == last_rise) begin
            req  = 1'b1;
            mult = 8'd77;
            div  = 8'd88;
         end
         if (n == sd_at) scandone = 1'b1;
         if (areset) begin
            scandone = 1'b0;
            locked   = 1'b0;
         end else if (fall_idx >= 0) begin
            t  = n - fall_idx;
            nl = (t >= 20) && !(v.toggle && ((t - 20) % 500 == 499));
            if (nl && lock_idx < 0) lock_idx = n;
            locked = nl;
         end
         n++;
         @(negedge clk);
      end
      req = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         compare({tag, "_queue"}, 144'd0, 144'd1);
         return;
      end
      e = exp_q.pop_front();
      compare({tag, "_completed"}, 144'(obs_finished), 144'd1);
      compare({tag, "_done_pulses"}, 144'(obs_done), e.ok ? 144'd1 : 144'd0);
      compare({tag, "_error_pulses"}, 144'(obs_err), e.ok ? 144'd0 : 144'd1);
      compare({tag, "_err_code_held"}, 144'(obs_code_held), 144'(e.err));
      compare({tag, "_hold_while_busy"}, 144'(obs_hold_viol), 144'd0);
      compare({tag, "_scanclk_rises"}, 144'(obs_rises), e.legal ? 144'd144 : 144'd0);
      compare({tag, "_configupdate"}, 144'(obs_cfg), e.legal ? 144'd1 : 144'd0);
      compare({tag, "_areset_len"}, 144'(obs_areset_len),
              (e.legal && e.err != 2'd2) ? 144'd16 : 144'd0);
      compare({tag, "_busy_after"}, 144'(obs_busy_t1), 144'd0);
      if (!e.ok) compare({tag, "_err_code"}, 144'(obs_code), 144'(e.err));
      if (e.legal) begin
         compare({tag, "_chain"}, obs_chain, e.chain);
         compare({tag, "_cfg_gap"}, 144'(obs_cfg_gap), 144'd1);
         compare({tag, "_hold_first_idle"}, 144'(obs_hold_t1), 144'd1);
      end else begin
         compare({tag, "_busy_never"}, 144'(obs_busy), 144'd0);
      end
      if (e.ok) begin
         compare({tag, "_lock_to_done"}, 144'(obs_lock2done), 144'd1024);
         compare({tag, "_hold_drop"}, 144'(obs_hold_t2), 144'd0);
      end
      if (e.err == 2'd3) compare({tag, "_areset_at_fail"}, 144'(obs_areset_at_err), 144'd0);
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   n;
      logic seen;
      tests = 0;
      fails = 0;

      vecs[0] = '{8'd5,   8'd6,  10, 1'b0, 1'b0, 2'd0, 18'h00702, 18'h00603};
      vecs[1] = '{8'd0,   8'd3,  10, 1'b0, 1'b0, 2'd1, 18'h00000, 18'h00000};
      vecs[2] = '{8'd1,   8'd1,  10, 1'b0, 1'b0, 2'd0, 18'h20000, 18'h20000};
      vecs[3] = '{8'd255, 8'd2,  10, 1'b1, 1'b0, 2'd3, 18'h1017F, 18'h00201};
      vecs[4] = '{8'd7,   8'd0,  10, 1'b0, 1'b0, 2'd1, 18'h00000, 18'h00000};
      vecs[5] = '{8'd9,   8'd4,  -1, 1'b0, 1'b1, 2'd2, 18'h00B04, 18'h00402};
      post_rst = '{8'd3, 8'd200, 5, 1'b0, 1'b0, 2'd0, modelField(3), modelField(200)};

      reset_n = 1'b0;
      repeat (4) @(negedge clk);
      compare("reset_outputs",
              144'({busy, done, error, err_code, hold, scanclk, scandata, scanclkena, configupdate, areset}),
              144'(11'b000_00_1_00000));
      reset_n = 1'b1;
      @(negedge clk);
      compare("idle_hold_follows_locked", 144'(hold), 144'd0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("op%0d", i));
      end

      // Abort a transfer with reset in the 100th shift cycle.
      locked = 1'b1;
      mult = 8'd12;
      div = 8'd13;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 10) begin
         if (scanclkena) seen = 1'b1;
         else begin
            n++;
            @(negedge clk);
         end
      end
      compare("rst_shift_started", 144'(seen), 144'd1);
      repeat (100) @(negedge clk);
      compare("rst_pre_busy_ena", 144'({busy, scanclkena}), 144'(2'b11));
      reset_n = 1'b0;
      @(negedge clk);
      compare("rst_abort_outputs",
              144'({busy, done, error, err_code, hold, scanclk, scanclkena, configupdate, areset}),
              144'(10'b000_00_1_0000));
      reset_n = 1'b1;
      @(negedge clk);
      compare("rst_hold_release", 144'(hold), 144'd0);

      applyStimulus(post_rst);
      checkOutput("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
